// File: rtl/regfile_neg_pkg.sv
// rtl/regfile_neg_pkg.sv - shared register-file geometry for decode, writeback and bypass logic
package regfile_neg_pkg;

  localparam int REG_WIDTH  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DEPTH  = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef logic [REG_WIDTH-1:0]  reg_data_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_neg_if.sv
// rtl/regfile_neg_if.sv - writeback write port and decode read ports of the register file
interface regfile_neg_if;
  import regfile_neg_pkg::*;

  logic      ctrl_writeEnable;
  reg_addr_t ctrl_writeReg;
  reg_data_t data_writeReg;
  reg_addr_t ctrl_readRegA;
  reg_addr_t ctrl_readRegB;
  reg_data_t data_readRegA;
  reg_data_t data_readRegB;

  modport master (
    output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    output data_readRegA, data_readRegB
  );

endinterface

// File: rtl/regfile_neg_reg_neg_en.sv
// rtl/regfile_neg_reg_neg_en.sv - falling-edge register with enable and async active-low clear
module reg_neg_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_neg.sv
// rtl/regfile_neg.sv - 32x32 register file, falling-edge write, two combinational read ports
module regfile_neg
  import regfile_neg_pkg::*;
#(
  parameter int WIDTH  = REG_WIDTH,
  parameter int DEPTH  = REG_DEPTH,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic          clk,
  input  logic          clr,
  regfile_neg_if.slave  bus
);

  logic [DEPTH-1:1]            wr_en;
  logic [DEPTH-1:0][WIDTH-1:0] regs;

  // Entry 0 has no enable bit, so the decode is one-hot over r1..rN and r0 writes vanish.
  always_comb begin
    wr_en = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wr_en[i] = bus.ctrl_writeEnable && (bus.ctrl_writeReg == ADDR_W'(i));
    end
  end

  assign regs[0] = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_reg
    reg_neg_en #(.WIDTH(WIDTH)) u_reg (
      .clk (clk),
      .clr (clr),
      .en  (wr_en[i]),
      .d   (bus.data_writeReg),
      .q   (regs[i])
    );
  end

  // No bypass: the half-cycle between the falling-edge write and the next rising edge forwards.
  assign bus.data_readRegA = regs[bus.ctrl_readRegA];
  assign bus.data_readRegB = regs[bus.ctrl_readRegB];

endmodule

// File: tb/tb_regfile_neg.sv
// tb/tb_regfile_neg.sv - self-checking bench for regfile_neg against an array reference model
module tb_regfile_neg;

  logic clk;
  logic clr;
  int   checks;
  int   fails;
  logic [31:0] model [32];

  regfile_neg_if bus ();

  regfile_neg u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write through the port and mirror the architectural effect in the model.
  task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
    @(posedge clk);
    #1;
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = addr;
    bus.data_writeReg    = data;
    @(negedge clk);
    #1;
    if (clr && addr != 5'd0) model[addr] = data;
    bus.ctrl_writeEnable = 1'b0;
  endtask

  task automatic test_reset_state();
    for (int i = 0; i < 32; i += 7) begin
      bus.ctrl_readRegA = 5'(i);
      bus.ctrl_readRegB = 5'(31 - i);
      #1;
      checks++;
      if (bus.data_readRegA !== 32'h0) begin
        fails++;
        $display("FAIL reset_state_a r%0d: got %h expected %h", i, bus.data_readRegA, 32'h0);
      end
      checks++;
      if (bus.data_readRegB !== 32'h0) begin
        fails++;
        $display("FAIL reset_state_b r%0d: got %h expected %h", 31 - i, bus.data_readRegB, 32'h0);
      end
    end
  endtask

  task automatic test_reset();
    do_write(5'd5, 32'hDEADBEEF);
    do_write(5'd31, 32'h1);
    bus.ctrl_readRegA = 5'd5;
    bus.ctrl_readRegB = 5'd31;
    #1;
    checks++;
    if (bus.data_readRegA !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL reset_prewrite r5: got %h expected %h", bus.data_readRegA, 32'hDEADBEEF);
    end
    @(posedge clk);
    #2;
    clr = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    #1;
    checks++;
    if (bus.data_readRegA !== model[5]) begin
      fails++;
      $display("FAIL reset_async r5: got %h expected %h", bus.data_readRegA, model[5]);
    end
    checks++;
    if (bus.data_readRegB !== model[31]) begin
      fails++;
      $display("FAIL reset_async r31: got %h expected %h", bus.data_readRegB, model[31]);
    end
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd5;
    bus.data_writeReg    = 32'h5A5A5A5A;
    @(negedge clk);
    #1;
    bus.ctrl_writeEnable = 1'b0;
    checks++;
    if (bus.data_readRegA !== 32'h0) begin
      fails++;
      $display("FAIL reset_write_ignored r5: got %h expected %h", bus.data_readRegA, 32'h0);
    end
    clr = 1'b1;
    #1;
    checks++;
    if (bus.data_readRegA !== 32'h0) begin
      fails++;
      $display("FAIL reset_release r5: got %h expected %h", bus.data_readRegA, 32'h0);
    end
    checks++;
    if (bus.data_readRegB !== 32'h0) begin
      fails++;
      $display("FAIL reset_release r31: got %h expected %h", bus.data_readRegB, 32'h0);
    end
  endtask

  task automatic test_basic();
    logic [31:0] prior;
    prior = model[7];
    @(posedge clk);
    #1;
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd7;
    bus.data_writeReg    = 32'h12345678;
    bus.ctrl_readRegA    = 5'd7;
    bus.ctrl_readRegB    = 5'd7;
    #1;
    checks++;
    if (bus.data_readRegA !== prior || bus.data_readRegB !== prior) begin
      fails++;
      $display("FAIL basic_before_edge r7: got %h/%h expected %h", bus.data_readRegA, bus.data_readRegB, prior);
    end
    @(negedge clk);
    #1;
    bus.ctrl_writeEnable = 1'b0;
    model[7] = 32'h12345678;
    checks++;
    if (bus.data_readRegA !== model[7] || bus.data_readRegB !== model[7]) begin
      fails++;
      $display("FAIL basic_after_edge r7: got %h/%h expected %h", bus.data_readRegA, bus.data_readRegB, model[7]);
    end
  endtask

  task automatic test_zero_reg();
    do_write(5'd0, 32'hFFFFFFFF);
    bus.ctrl_readRegA = 5'd0;
    bus.ctrl_readRegB = 5'd7;
    #1;
    checks++;
    if (bus.data_readRegA !== 32'h0) begin
      fails++;
      $display("FAIL zero_reg r0: got %h expected %h", bus.data_readRegA, 32'h0);
    end
    checks++;
    if (bus.data_readRegB !== model[7]) begin
      fails++;
      $display("FAIL zero_reg_no_alias r7: got %h expected %h", bus.data_readRegB, model[7]);
    end
  endtask

  task automatic test_enable_low();
    do_write(5'd3, 32'hAAAA5555);
    @(posedge clk);
    #1;
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = 5'd3;
    bus.data_writeReg    = 32'h0;
    bus.ctrl_readRegA    = 5'd3;
    @(negedge clk);
    #1;
    checks++;
    if (bus.data_readRegA !== 32'hAAAA5555) begin
      fails++;
      $display("FAIL enable_low r3: got %h expected %h", bus.data_readRegA, 32'hAAAA5555);
    end
  endtask

  task automatic test_sweep();
    for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i) * 32'h01010101);
    for (int i = 0; i < 32; i++) begin
      bus.ctrl_readRegA = 5'(i);
      bus.ctrl_readRegB = 5'(31 - i);
      #1;
      checks++;
      if (bus.data_readRegA !== 32'(i) * 32'h01010101) begin
        fails++;
        $display("FAIL sweep_a r%0d: got %h expected %h", i, bus.data_readRegA, 32'(i) * 32'h01010101);
      end
      checks++;
      if (bus.data_readRegB !== 32'(31 - i) * 32'h01010101) begin
        fails++;
        $display("FAIL sweep_b r%0d: got %h expected %h", 31 - i, bus.data_readRegB, 32'(31 - i) * 32'h01010101);
      end
    end
  endtask

  task automatic test_forwarding();
    @(posedge clk);
    #1;
    bus.ctrl_writeEnable = 1'b1;
    bus.ctrl_writeReg    = 5'd9;
    bus.data_writeReg    = 32'hCAFEF00D;
    bus.ctrl_readRegA    = 5'd9;
    #1;
    checks++;
    if (bus.data_readRegA !== model[9]) begin
      fails++;
      $display("FAIL forward_before_edge r9: got %h expected %h", bus.data_readRegA, model[9]);
    end
    model[9] = 32'hCAFEF00D;
    @(posedge clk);
    checks++;
    if (bus.data_readRegA !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL forward_at_rise r9: got %h expected %h", bus.data_readRegA, 32'hCAFEF00D);
    end
    #1;
    bus.ctrl_writeEnable = 1'b0;
  endtask

  task automatic test_random();
    logic       we;
    logic [4:0] wa;
    logic [31:0] wd;
    logic [4:0] ra;
    logic [4:0] rb;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ra = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      rb = 5'($urandom_range(0, 31));
      @(posedge clk);
      #1;
      bus.ctrl_writeEnable = we;
      bus.ctrl_writeReg    = wa;
      bus.data_writeReg    = wd;
      bus.ctrl_readRegA    = ra;
      bus.ctrl_readRegB    = rb;
      #1;
      checks++;
      if (bus.data_readRegA !== model[ra] || bus.data_readRegB !== model[rb]) begin
        fails++;
        $display("FAIL random_old n=%0d: got %h/%h expected %h/%h", n, bus.data_readRegA, bus.data_readRegB, model[ra], model[rb]);
      end
      @(negedge clk);
      #1;
      if (we && wa != 5'd0) model[wa] = wd;
      checks++;
      if (bus.data_readRegA !== model[ra] || bus.data_readRegB !== model[rb]) begin
        fails++;
        $display("FAIL random_new n=%0d: got %h/%h expected %h/%h", n, bus.data_readRegA, bus.data_readRegB, model[ra], model[rb]);
      end
    end
    bus.ctrl_writeEnable = 1'b0;
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    clr                  = 1'b0;
    bus.ctrl_writeEnable = 1'b0;
    bus.ctrl_writeReg    = 5'd0;
    bus.data_writeReg    = 32'h0;
    bus.ctrl_readRegA    = 5'd0;
    bus.ctrl_readRegB    = 5'd0;
    #12;
    test_reset_state();
    clr = 1'b1;
    test_reset();
    test_basic();
    test_zero_reg();
    test_enable_low();
    test_sweep();
    test_forwarding();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
